mcp4811_drv: RTL and testbench
==============================

MCP4811_DRV -- requirements
Module: mcp4811_drv

Interface
REQ-001 Parameter DAC_DATA_W, default 10: DAC code width.
REQ-002 Parameter SCK_DIV, default 2, minimum 1: clk cycles per SCK half-period.
REQ-003 Parameter LD_W, default 2, minimum 1: clk cycles that dac_ld_n is held low.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 din  in  DAC_DATA_W  DAC code to send.
REQ-007 din_valid  in  1  din is valid this cycle.
REQ-008 din_ready  out  1  block can accept din this cycle.
REQ-009 busy  out  1  frame or LDAC pulse in progress, or a code is pending.
REQ-010 dac_cs_n  out  1  SPI chip select, active-low.
REQ-011 dac_sck  out  1  SPI clock, idle low.
REQ-012 dac_sdi  out  1  SPI data, MSB first.
REQ-013 dac_ld_n  out  1  DAC latch strobe, active-low.

Function
REQ-014 Transfer: din is accepted on any rising clk edge where din_valid and din_ready are both 1.
REQ-015 Buffer: a one-entry pending register holds accepted codes. din_ready = not pending_full. Input is accepted during a frame.
REQ-016 Frame: 16 bits, MSB first.
- bit15 = 0 (write)
- bit14 = 0 (don't care)
- bit13 = 1 (gain x1)
- bit12 = 1 (active)
- bits11..2 = code[9:0]
- bits1..0 = 0
REQ-017 FSM states: IDLE, SHIFT, CS_HOLD, LDAC. Any other encoding returns to IDLE.
REQ-018 IDLE -> SHIFT when a code is pending.
- The pending code is loaded into the shift register on that edge and the pending register is freed.
- dac_cs_n goes low and bit15 is driven on the same edge.
REQ-019 SHIFT: dac_sck rises SCK_DIV cycles after dac_cs_n falls, then toggles every SCK_DIV cycles. This gives exactly 16 rising edges.
REQ-020 dac_sdi changes only on dac_sck falling edges, or at frame start. It is stable for SCK_DIV cycles before and after each rising edge.
REQ-021 SHIFT -> CS_HOLD on the 16th dac_sck falling edge, which is driven low. dac_cs_n rises SCK_DIV cycles later.
REQ-022 CS_HOLD -> LDAC SCK_DIV cycles after dac_cs_n rises.
- dac_ld_n is low for LD_W cycles, then returns high.
- The FSM then goes to IDLE.
REQ-023 Cycle timing, with accept at edge 0 into an empty, idle block:
- dac_cs_n low at edge 1
- k-th rising dac_sck (k = 0..15) at edge 1+SCK_DIV+2·SCK_DIV·k
- dac_cs_n high at edge 1+33·SCK_DIV
- dac_ld_n low over edges 1+34·SCK_DIV .. 1+34·SCK_DIV+LD_W-1
REQ-024 Back-to-back: if a code is pending when LDAC ends, IDLE lasts exactly one cycle before the next frame. dac_cs_n therefore stays high for at least SCK_DIV+LD_W+1 cycles.
REQ-025 Simultaneous load and accept: if the pending register is freed on the same edge a new code is accepted, the new code occupies the pending register with no loss.
REQ-026 dac_ld_n and dac_cs_n are never both low.
REQ-027 dac_sck is low whenever dac_cs_n is high.
REQ-028 busy = (state != IDLE) or pending_full.
REQ-029 All SPI outputs are registered (glitch-free). The counters are sized to hold max(2·SCK_DIV, LD_W).

Reset
REQ-030 While rst_n is low, outputs are:
- dac_cs_n = 1, dac_sck = 0, dac_sdi = 0, dac_ld_n = 1
- din_ready = 0, busy = 0
- state IDLE, pending register empty
REQ-031 din_ready goes to 1 on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-frame aborts the frame with no dac_ld_n pulse. The pending code is discarded.

Structure
REQ-033 A shared package holds the FSM state typedef and the fixed frame header constant (4'b0011) with its field names.
REQ-034 One sub-module, mcp4811_drv_tick: a SCK_DIV prescaler producing the half-period strobe, held reset while in IDLE.

Verification
REQ-035 Bench instantiates this block driving the MCP4811 behavioural model, with SCK_DIV=2 and LD_W=2.
REQ-036 Single write of 0x2A5:
- SDI bit sequence 0,0,1,1,1010100101,0,0
- 16 sck rises; cs_n high at cycle 67; ld_n low for 2 cycles
- model reports DAC output 0x2a5 with no header errors
REQ-037 Boundary codes 0x000 then 0x3FF -> model reports 0x000 then 0x3ff.
REQ-038 Three codes with din_valid held high:
- din_ready drops after the second code is accepted and returns after the first frame starts
- all three codes reported in order
- cs_n high gap of at least 5 cycles between frames
REQ-039 rst_n low at the 8th sck rise of 0x155:
- cs_n high and sck low immediately
- no ld_n pulse, no model output
- a following write of 0x0F0 reports 0x0f0
REQ-040 Assertions over all tests:
- sck low while cs_n high
- never cs_n and ld_n both low
- sdi stable around each sck rise

Source files
------------

// File: rtl/mcp4811_drv_pkg.sv
// Shared types and constants for the MCP4811 SPI DAC driver.
// Holds the FSM state encoding and the fixed command header placed in front of every code.
package mcp4811_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2,
    ST_LDAC    = 2'd3
  } state_t;

  localparam int FRAME_W = 16;
  localparam int CODE_W  = 10;

  // Command nibble: write, don't care, gain x1 (GA_n=1), output active (SHDN_n=1)
  localparam logic FRAME_WRITE_N   = 1'b0;
  localparam logic FRAME_DONT_CARE = 1'b0;
  localparam logic FRAME_GA_N      = 1'b1;
  localparam logic FRAME_SHDN_N    = 1'b1;
  localparam logic [3:0] FRAME_HDR = {FRAME_WRITE_N, FRAME_DONT_CARE, FRAME_GA_N, FRAME_SHDN_N};

  function automatic logic [FRAME_W-1:0] build_frame(input logic [CODE_W-1:0] code);
    return {FRAME_HDR, code, 2'b00};
  endfunction

endpackage

// File: rtl/mcp4811_drv_tick.sv
// SCK half-period prescaler: one-cycle strobe every SCK_DIV clocks, held at zero while clear is high.
module mcp4811_drv_tick #(
  parameter int SCK_DIV = 2,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = ~clear & (cnt == LAST);

endmodule

// File: rtl/mcp4811_drv.sv
// MCP4811 driver: one-entry input buffer, 16-bit SPI write frame, then an LDAC latch pulse.
// All SPI pins come straight from flops so the DAC never sees combinational glitches.
module mcp4811_drv
  import mcp4811_drv_pkg::*;
#(
  parameter int DAC_DATA_W = 10,
  parameter int SCK_DIV    = 2,
  parameter int LD_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DAC_DATA_W-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  busy,
  output logic                  dac_cs_n,
  output logic                  dac_sck,
  output logic                  dac_sdi,
  output logic                  dac_ld_n
);

  localparam int CNT_MAX = (2 * SCK_DIV > LD_W) ? 2 * SCK_DIV : LD_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state, state_nx;
  logic [FRAME_W-1:0]   shreg, shreg_nx;
  logic [3:0]           fall_cnt, fall_cnt_nx;
  logic                 hold_phase, hold_phase_nx;
  logic [CNT_W-1:0]     ld_cnt, ld_cnt_nx;
  logic                 sck_nx, sdi_nx, cs_n_nx, ld_n_nx;
  logic [DAC_DATA_W-1:0] pend;
  logic                 pend_full;
  logic                 ready_q;
  logic                 tick;
  logic                 accept;
  logic                 load;

  assign din_ready = ready_q & ~pend_full;
  assign accept    = din_valid & din_ready;
  assign load      = (state == ST_IDLE) & pend_full;
  assign busy      = (state != ST_IDLE) | pend_full;

  mcp4811_drv_tick #(
    .SCK_DIV (SCK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  // A code accepted on the same edge the old one is loaded simply takes over the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      pend_full <= 1'b0;
      pend      <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        pend      <= din;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      fall_cnt   <= '0;
      hold_phase <= 1'b0;
      ld_cnt     <= '0;
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ld_n   <= 1'b1;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      fall_cnt   <= fall_cnt_nx;
      hold_phase <= hold_phase_nx;
      ld_cnt     <= ld_cnt_nx;
      dac_cs_n   <= cs_n_nx;
      dac_sck    <= sck_nx;
      dac_sdi    <= sdi_nx;
      dac_ld_n   <= ld_n_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    fall_cnt_nx   = fall_cnt;
    hold_phase_nx = hold_phase;
    ld_cnt_nx     = ld_cnt;
    cs_n_nx       = dac_cs_n;
    sck_nx        = dac_sck;
    sdi_nx        = dac_sdi;
    ld_n_nx       = dac_ld_n;

    case (state)
      ST_IDLE: begin
        if (pend_full) begin
          state_nx    = ST_SHIFT;
          shreg_nx    = build_frame(CODE_W'(pend));
          sdi_nx      = shreg_nx[FRAME_W-1];
          cs_n_nx     = 1'b0;
          sck_nx      = 1'b0;
          fall_cnt_nx = '0;
        end
      end

      // Data moves only on falling SCK so it is centred around every rising edge.
      ST_SHIFT: begin
        if (tick) begin
          if (!dac_sck) begin
            sck_nx = 1'b1;
          end else begin
            sck_nx = 1'b0;
            if (fall_cnt == 4'd15) begin
              state_nx      = ST_CS_HOLD;
              hold_phase_nx = 1'b0;
              sdi_nx        = 1'b0;
            end else begin
              fall_cnt_nx = fall_cnt + 4'd1;
              sdi_nx      = shreg[FRAME_W-2];
              shreg_nx    = {shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end

      ST_CS_HOLD: begin
        if (tick) begin
          if (!hold_phase) begin
            cs_n_nx       = 1'b1;
            hold_phase_nx = 1'b1;
          end else begin
            state_nx  = ST_LDAC;
            ld_n_nx   = 1'b0;
            ld_cnt_nx = '0;
          end
        end
      end

      ST_LDAC: begin
        if (ld_cnt == CNT_W'(LD_W - 1)) begin
          ld_n_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          ld_cnt_nx = ld_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cs_n_nx  = 1'b1;
        sck_nx   = 1'b0;
        sdi_nx   = 1'b0;
        ld_n_nx  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mcp4811_drv.sv
// Directed bench for mcp4811_drv with an inline MCP4811 behavioural model and protocol monitors.
// Edge numbers are posedge counts; the accept edge of each write is edge 0 of that write.
module tb_mcp4811_drv;

  localparam int DW = 10;
  localparam int SD = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, busy, dac_cs_n, dac_sck, dac_sdi, dac_ld_n;

  mcp4811_drv #(
    .DAC_DATA_W (DW),
    .SCK_DIV    (SD),
    .LD_W       (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .dac_cs_n  (dac_cs_n),
    .dac_sck   (dac_sck),
    .dac_sdi   (dac_sdi),
    .dac_ld_n  (dac_ld_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // DAC model and protocol monitor, sampled on the falling clk edge
  logic [15:0] mdl_sr = '0;
  logic [15:0] last_frame = '0;
  logic        frame_ok = 1'b0;
  logic [9:0]  dac_q[$];
  int          gaps[$];
  int mdl_bits = 0, rise_cnt = 0, first_rise_e = 0, last_rise_e = 0;
  int cs_fall_e = 0, cs_rise_e = 0, ld_fall_e = 0, ld_fall_cnt = 0, ld_low_cycles = 0;
  int sdi_chg_e = 0, hdr_err = 0, aborted = 0;
  int viol_idle = 0, viol_both = 0, viol_sdi = 0;
  logic have_cs_rise = 1'b0;
  logic prev_cs_n = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0, prev_ld_n = 1'b1;

  always @(negedge clk) begin
    if (dac_cs_n && dac_sck) viol_idle++;
    if (!dac_cs_n && !dac_ld_n) viol_both++;
    if (dac_sdi != prev_sdi) begin
      sdi_chg_e = ncyc;
      if (prev_sck && dac_sck) viol_sdi++;
    end
    if (!dac_cs_n && prev_cs_n) begin
      if (have_cs_rise) gaps.push_back(ncyc - cs_rise_e);
      cs_fall_e = ncyc;
      rise_cnt  = 0;
      mdl_bits  = 0;
    end
    if (dac_sck && !prev_sck) begin
      if (ncyc - sdi_chg_e < SD) viol_sdi++;
      if (rise_cnt == 0) first_rise_e = ncyc;
      last_rise_e = ncyc;
      rise_cnt++;
      mdl_sr = {mdl_sr[14:0], dac_sdi};
      mdl_bits++;
    end
    if (dac_cs_n && !prev_cs_n) begin
      cs_rise_e    = ncyc;
      have_cs_rise = 1'b1;
      last_frame   = mdl_sr;
      frame_ok     = (mdl_bits == 16);
      if (mdl_bits != 16) aborted++;
      if (frame_ok && (mdl_sr[15:12] != 4'b0011 || mdl_sr[1:0] != 2'b00)) begin
        hdr_err++;
        frame_ok = 1'b0;
      end
    end
    if (!dac_ld_n) ld_low_cycles++;
    if (!dac_ld_n && prev_ld_n) begin
      ld_fall_cnt++;
      ld_fall_e = ncyc;
      if (frame_ok) dac_q.push_back(last_frame[11:2]);
      frame_ok = 1'b0;
    end
    prev_cs_n = dac_cs_n;
    prev_sck  = dac_sck;
    prev_sdi  = dac_sdi;
    prev_ld_n = dac_ld_n;
  end

  int acc_e = 0;

  task automatic applyStimulus(input logic [DW-1:0] code);
    int t;
    @(negedge clk);
    din       = code;
    din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput("din_accepted", din_ready, 1);
    acc_e = ncyc + 1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || !dac_ld_n) && t < 2000);
    checkOutput("idle_reached", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_q, base_ld, base_gap, base_ldf, a0, a1, r, t;
    logic ps;
    logic [DW-1:0] codes[3];
    int ready_after[3];
    int acc_rel[3];

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", dac_cs_n, 1);
    checkOutput("rst_sck", dac_sck, 0);
    checkOutput("rst_sdi", dac_sdi, 0);
    checkOutput("rst_ld_n", dac_ld_n, 1);
    checkOutput("rst_ready", din_ready, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", din_ready, 1);

    // Single write of 0x2A5 with full timing check
    base_q  = dac_q.size();
    base_ld = ld_low_cycles;
    applyStimulus(10'h2A5);
    a0 = acc_e;
    waitIdle();
    checkOutput("t1_cs_fall", cs_fall_e - a0, 1);
    checkOutput("t1_first_rise", first_rise_e - a0, 3);
    checkOutput("t1_last_rise", last_rise_e - a0, 63);
    checkOutput("t1_rise_count", rise_cnt, 16);
    checkOutput("t1_cs_rise", cs_rise_e - a0, 67);
    checkOutput("t1_ld_fall", ld_fall_e - a0, 69);
    checkOutput("t1_ld_width", ld_low_cycles - base_ld, 2);
    checkOutput("t1_frame_bits", last_frame, 16'h3A94);
    checkOutput("t1_out_count", dac_q.size(), base_q + 1);
    checkOutput("t1_out_value", dac_q[base_q], 10'h2A5);

    // Boundary codes
    base_q = dac_q.size();
    applyStimulus(10'h000);
    waitIdle();
    applyStimulus(10'h3FF);
    waitIdle();
    checkOutput("t2_out_count", dac_q.size(), base_q + 2);
    checkOutput("t2_out_zero", dac_q[base_q], 10'h000);
    checkOutput("t2_out_full", dac_q[base_q + 1], 10'h3FF);

    // Three codes with din_valid held high
    codes[0] = 10'h111;
    codes[1] = 10'h222;
    codes[2] = 10'h333;
    base_q   = dac_q.size();
    base_gap = gaps.size();
    @(negedge clk);
    din_valid = 1'b1;
    a1 = 0;
    for (int i = 0; i < 3; i++) begin
      din = codes[i];
      t = 0;
      while (!din_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      checkOutput("t3_accept", din_ready, 1);
      if (i == 0) a1 = ncyc + 1;
      acc_rel[i] = ncyc + 1 - a1;
      @(negedge clk);
      ready_after[i] = din_ready;
    end
    din_valid = 1'b0;
    waitIdle();
    checkOutput("t3_ready_after_1st", ready_after[0], 0);
    checkOutput("t3_ready_after_2nd", ready_after[1], 0);
    checkOutput("t3_ready_after_3rd", ready_after[2], 0);
    checkOutput("t3_accept_2nd_edge", acc_rel[1], 2);
    checkOutput("t3_accept_3rd_edge", acc_rel[2], 73);
    checkOutput("t3_out_count", dac_q.size(), base_q + 3);
    checkOutput("t3_out_0", dac_q[base_q], 10'h111);
    checkOutput("t3_out_1", dac_q[base_q + 1], 10'h222);
    checkOutput("t3_out_2", dac_q[base_q + 2], 10'h333);
    checkOutput("t3_gap_count", gaps.size(), base_gap + 3);
    checkOutput("t3_gap_a", gaps[base_gap + 1], SD + LW + 1);
    checkOutput("t3_gap_b", gaps[base_gap + 2], SD + LW + 1);

    // Reset at the 8th sck rise of 0x155
    base_q   = dac_q.size();
    base_ldf = ld_fall_cnt;
    applyStimulus(10'h155);
    t = 0;
    while (dac_cs_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("t4_frame_started", dac_cs_n, 0);
    r  = 0;
    ps = dac_sck;
    t  = 0;
    while (r < 8 && t < 200) begin
      @(negedge clk);
      if (dac_sck && !ps) r++;
      ps = dac_sck;
      t++;
    end
    checkOutput("t4_reached_8th_rise", r, 8);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_cs_n_abort", dac_cs_n, 1);
    checkOutput("t4_sck_abort", dac_sck, 0);
    checkOutput("t4_ld_n_abort", dac_ld_n, 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_busy_in_reset", busy, 0);
    checkOutput("t4_ready_in_reset", din_ready, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t4_no_ld_pulse", ld_fall_cnt, base_ldf);
    checkOutput("t4_no_output", dac_q.size(), base_q);
    checkOutput("t4_idle_after_reset", busy, 0);
    applyStimulus(10'h0F0);
    waitIdle();
    checkOutput("t4_out_count", dac_q.size(), base_q + 1);
    checkOutput("t4_out_value", dac_q[base_q], 10'h0F0);

    // Protocol invariants over the whole run
    checkOutput("sck_low_while_cs_high", viol_idle, 0);
    checkOutput("cs_ld_never_both_low", viol_both, 0);
    checkOutput("sdi_stable_around_rise", viol_sdi, 0);
    checkOutput("header_errors", hdr_err, 0);
    checkOutput("aborted_frames", aborted, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
